lut_mod_reduce_pipe: RTL and testbench

- Pipelined, parametrised modular reducer for NTT butterfly products: x (IN_W bits) -> x mod Q.
- Splits x into a BASE_W-bit low part plus NCH = (IN_W-BASE_W)/CHUNK_W upper chunks.
- Each chunk maps through its own constant table, entry c -> (c * 2^(BASE_W + k*CHUNK_W)) mod Q. The results are summed and then corrected into [0, Q).
- Sits between the modular multiplier and the butterfly add/sub stage, with valid/ready flow control and a tag carried alongside the data.

---
 rtl/ntt_mod_pkg.sv | 42 ++++
 rtl/lut_mod_rom.sv | 21 ++
 rtl/lut_mod_reduce_pipe.sv | 110 +++++++++++
 tb/tb_lut_mod_reduce_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_mod_pkg.sv
// rtl/ntt_mod_pkg.sv - shared constants and elaboration-time helpers for the LUT modular reducer
package ntt_mod_pkg;

    function automatic int clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >>> 1;
        end
        return r;
    endfunction

    // 64-bit so (c << shift) cannot overflow for any practical table
    function automatic longint unsigned lut_entry(input longint unsigned c, input int shift,
                                                  input longint unsigned q);
        return (c << shift) % q;
    endfunction

    function automatic int nch_of(input int in_w, input int base_w, input int chunk_w);
        return (in_w - base_w) / chunk_w;
    endfunction

    function automatic int sum_w_of(input int q, input int base_w, input int nch);
        return clog2((longint'(1) << base_w) + longint'(nch) * longint'(q - 1) + 1);
    endfunction

    function automatic int mmax_of(input int q, input int base_w, input int nch);
        return int'(((longint'(1) << base_w) - 1 + longint'(nch) * longint'(q - 1)) / longint'(q));
    endfunction

    localparam int Q       = 3329;
    localparam int IN_W    = 24;
    localparam int BASE_W  = 12;
    localparam int CHUNK_W = 4;
    localparam int NCH     = nch_of(IN_W, BASE_W, CHUNK_W);
    localparam int SUM_W   = sum_w_of(Q, BASE_W, NCH);
    localparam int MMAX    = mmax_of(Q, BASE_W, NCH);

endpackage

// File: rtl/lut_mod_rom.sv
// rtl/lut_mod_rom.sv - constant table mapping one input chunk c to (c * 2^SHIFT) mod Q
module lut_mod_rom #(
    parameter int Q       = ntt_mod_pkg::Q,
    parameter int SHIFT   = 12,
    parameter int CHUNK_W = 4,
    parameter int BASE_W  = 12
) (
    input  logic [CHUNK_W-1:0] idx,
    output logic [BASE_W-1:0]  data
);
    import ntt_mod_pkg::*;

    logic [BASE_W-1:0] rom_tab [2**CHUNK_W];

    for (genvar c = 0; c < 2**CHUNK_W; c++) begin : g_ent
        assign rom_tab[c] = BASE_W'(lut_entry(64'(c), SHIFT, 64'(Q)));
    end

    assign data = rom_tab[idx];

endmodule

// File: rtl/lut_mod_reduce_pipe.sv
// rtl/lut_mod_reduce_pipe.sv - 3-stage valid/ready pipeline reducing x to x mod Q via chunk tables
module lut_mod_reduce_pipe #(
    parameter int Q       = ntt_mod_pkg::Q,
    parameter int IN_W    = 24,
    parameter int BASE_W  = 12,
    parameter int CHUNK_W = 4,
    parameter int TAG_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BASE_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);
    import ntt_mod_pkg::*;

    localparam int NCH   = nch_of(IN_W, BASE_W, CHUNK_W);
    localparam int SUM_W = sum_w_of(Q, BASE_W, NCH);
    localparam int MMAX  = mmax_of(Q, BASE_W, NCH);

    logic                        v1, v2, v3;
    logic                        r1, r2, r3;
    logic [BASE_W-1:0]           s1_low;
    logic [NCH-1:0][BASE_W-1:0]  s1_lut;
    logic [NCH-1:0][BASE_W-1:0]  lut_out;
    logic [TAG_W-1:0]            s1_tag, s2_tag;
    logic [SUM_W-1:0]            s2_sum, sum_nxt;
    logic [BASE_W-1:0]           red_nxt;

    for (genvar k = 0; k < NCH; k++) begin : g_rom
        lut_mod_rom #(
            .Q      (Q),
            .SHIFT  (BASE_W + k * CHUNK_W),
            .CHUNK_W(CHUNK_W),
            .BASE_W (BASE_W)
        ) u_rom (
            .idx (in_data[BASE_W + k * CHUNK_W +: CHUNK_W]),
            .data(lut_out[k])
        );
    end

    assign r3        = !v3 | out_ready;
    assign r2        = !v2 | r3;
    assign r1        = !v1 | r2;
    assign in_ready  = r1;
    assign out_valid = v3;
    assign busy      = v1 | v2 | v3;

    always_comb begin
        sum_nxt = SUM_W'(s1_low);
        for (int k = 0; k < NCH; k++) begin
            sum_nxt = sum_nxt + SUM_W'(s1_lut[k]);
        end
    end

    // Thresholds m*Q are elaboration constants; the last one satisfied picks the subtrahend
    always_comb begin
        red_nxt = BASE_W'(s2_sum);
        for (int m = 1; m <= MMAX; m++) begin
            if (s2_sum >= SUM_W'(m * Q)) begin
                red_nxt = BASE_W'(s2_sum - SUM_W'(m * Q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_low   <= '0;
            s1_lut   <= '0;
            s1_tag   <= '0;
            s2_sum   <= '0;
            s2_tag   <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (r1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_low <= in_data[BASE_W-1:0];
                    s1_lut <= lut_out;
                    s1_tag <= in_tag;
                end
            end
            if (r2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sum <= sum_nxt;
                    s2_tag <= s1_tag;
                end
            end
            if (r3) begin
                v3 <= v2;
                if (v2) begin
                    out_data <= red_nxt;
                    out_tag  <= s2_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_mod_reduce_pipe.sv
// tb/tb_lut_mod_reduce_pipe.sv - randomized self-checking bench against a plain x % Q reference
module tb_lut_mod_reduce_pipe;

    localparam int Q  = 3329;
    localparam int VQ = 7681;

    typedef struct {
        logic [11:0] d;
        logic [7:0]  t;
        int          c;
    } exp_t;

    typedef struct {
        logic [12:0] d;
        logic [7:0]  t;
    } vexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [7:0]  out_tag;
    logic        busy;

    logic        v_rst = 1'b1;
    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [27:0] v_in_data = '0;
    logic [7:0]  v_in_tag = '0;
    logic        v_out_valid;
    logic        v_out_ready = 1'b1;
    logic [12:0] v_out_data;
    logic [7:0]  v_out_tag;
    logic        v_busy;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    inflight = 0;
    int    bp_mode = 0;
    logic  var_done = 1'b0;
    exp_t  q[$];
    vexp_t vq[$];

    always #5 clk = ~clk;

    lut_mod_reduce_pipe #(
        .Q(Q), .IN_W(24), .BASE_W(12), .CHUNK_W(4), .TAG_W(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    lut_mod_reduce_pipe #(
        .Q(VQ), .IN_W(28), .BASE_W(13), .CHUNK_W(5), .TAG_W(8)
    ) dut_var (
        .clk(clk), .rst(v_rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_data(v_in_data), .in_tag(v_in_tag), .out_valid(v_out_valid),
        .out_ready(v_out_ready), .out_data(v_out_data), .out_tag(v_out_tag), .busy(v_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic [23:0] d, input logic [7:0] t,
                         input logic [11:0] e, output logic acc);
        logic ordy;
        logic emi;
        case (bp_mode)
            0:       ordy = 1'b1;
            1:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ordy = ($urandom_range(3) != 0);
        endcase
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        check("busy", busy, inflight != 0);
        check("in_ready", in_ready, !(inflight == 3 && !ordy));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                check("out_data", out_data, q[0].d);
                check("out_tag", out_tag, q[0].t);
                check("out_lt_q", out_data < Q, 1);
                if (bp_mode == 0) check("latency", cyc - q[0].c, 2);
            end
        end
        acc = v && in_ready;
        emi = out_valid && ordy && (q.size() != 0);
        @(posedge clk);
        cyc++;
        if (emi) void'(q.pop_front());
        if (acc) q.push_back('{e, t, cyc});
        inflight += int'(acc) - int'(emi);
    endtask

    task automatic send(input logic [23:0] d, input logic [7:0] t, input logic [11:0] e);
        logic acc;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, d, t, e, acc);
            if (acc) return;
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic send_ref(input logic [23:0] d, input logic [7:0] t);
        send(d, t, 12'(d % Q));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0 && inflight == 0) break;
            cycle(1'b0, '0, '0, '0, acc);
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        inflight = 0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    initial begin : main
        logic acc;
        do_reset();

        bp_mode = 0;
        send(24'h000FFF, 8'd1, 12'd766);
        send(24'h001000, 8'd2, 12'd767);
        send(24'hFFFFFF, 8'd3, 12'd2384);
        send(24'd11075584, 8'd4, 12'd1);
        send(24'(Q), 8'd5, 12'd0);
        send(24'(Q - 1), 8'd6, 12'd3328);
        drain();

        for (int i = 0; i < 3; i++) send_ref(24'($urandom), 8'(i + 16));
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, '0, acc);

        bp_mode = 1;
        for (int i = 0; i < 10; i++) send_ref(24'($urandom), 8'(i));
        drain();

        bp_mode = 0;
        for (int lo = 0; lo < 4096; lo++) send_ref(24'hFFF000 | 24'(lo), 8'(lo));
        for (int ch = 0; ch < 4096; ch++) send_ref({12'(ch), 12'hFFF}, 8'(ch));
        drain();

        bp_mode = 2;
        for (int i = 0; i < 20000; i++) send_ref(24'($urandom), 8'($urandom));
        drain();

        for (int i = 0; i < 100000 && !var_done; i++) @(posedge clk);
        check("var_done", var_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : variant
        repeat (3) @(posedge clk);
        @(negedge clk);
        v_rst = 1'b0;
        for (int i = 0; i < 2008; i++) begin
            @(negedge clk);
            v_in_valid = (i < 2000);
            v_in_data  = 28'($urandom);
            v_in_tag   = 8'(i);
            #1;
            check("var_in_ready", v_in_ready, 1);
            if (v_out_valid) begin
                if (vq.size() == 0) begin
                    check("var_spurious", v_out_valid, 0);
                end else begin
                    check("var_out_data", v_out_data, vq[0].d);
                    check("var_out_tag", v_out_tag, vq[0].t);
                    void'(vq.pop_front());
                end
            end
            if (v_in_valid && v_in_ready) vq.push_back('{13'(v_in_data % VQ), v_in_tag});
        end
        check("var_throughput", vq.size(), 0);
        var_done = 1'b1;
    end

endmodule
